// File: rtl/tt_input_debounce.sv
// Input conditioner: two-flop synchroniser, per-channel stable-time debounce with
// one-cycle rise/fall pulses, and an optional rising-edge event counter built when
// the macro TT_EVENT_COUNT_EN is defined (tied to zero otherwise).
module tt_input_debounce #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         pin_in,
    output logic [CHANNELS-1:0]         level_out,
    output logic [CHANNELS-1:0]         rise_pulse,
    output logic [CHANNELS-1:0]         fall_pulse,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic                        clr_count,
    output logic [7:0]                  event_count,
    output logic                        count_ovf
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    // Plain flop-to-flop synchroniser; nothing may be inserted between s1 and s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == level_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    // Accept the new level; the pulse shares the edge with the level change.
                    level_out[i]  <= s2[i];
                    cnt[i]        <= '0;
                    rise_pulse[i] <= s2[i];
                    fall_pulse[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef TT_EVENT_COUNT_EN
    logic sel_rise;

    assign sel_rise = rise_pulse[sel];

    // Clear wins over a coincident increment; the overflow flag is sticky until cleared.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            event_count <= '0;
            count_ovf   <= 1'b0;
        end else if (sel_rise) begin
            event_count <= event_count + 8'd1;
            if (event_count == 8'hFF) begin
                count_ovf <= 1'b1;
            end
        end
    end
`else
    logic unused_count_inputs;

    assign unused_count_inputs = ^{sel, clr_count};
    assign event_count         = '0;
    assign count_ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_tt_input_debounce.sv
// Self-checking bench for tt_input_debounce: stimulus tasks feed a window-based
// reference model into an expected queue that a separate monitor drains every cycle.
module tb_tt_input_debounce;

    localparam int CH = 8;
    localparam int DB = 4;
`ifdef TT_EVENT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] pin_in = '0;
    logic [CH-1:0] level_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [2:0]    sel = '0;
    logic          clr_count = 1'b0;
    logic [7:0]    event_count;
    logic          count_ovf;

    int checks = 0;
    int errors = 0;

    // Expected word: {count_ovf, event_count, fall_pulse, rise_pulse, level_out}
    logic [32:0] exp_q[$];

    // Reference model state
    logic [7:0] sync_line[$];
    logic [7:0] s2_hist[$];
    logic [7:0] m_level = '0;
    logic [7:0] m_rise  = '0;
    logic [7:0] m_fall  = '0;
    logic [7:0] m_count = '0;
    logic       m_ovf   = 1'b0;

    tt_input_debounce #(.CHANNELS(CH), .CNT_W(16), .DEBOUNCE(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .pin_in     (pin_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .sel        (sel),
        .clr_count  (clr_count),
        .event_count(event_count),
        .count_ovf  (count_ovf)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: compare the DUT after every edge against the queued expectation
    always @(posedge clk) begin
        logic [32:0] exp_w;
        logic [32:0] got_w;
        #1;
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = {count_ovf, event_count, fall_pulse, rise_pulse, level_out};
            checks++;
            if (got_w !== exp_w) begin
                errors++;
                $display("FAIL outputs t=%0t got ovf=%b cnt=%h fall=%h rise=%h lvl=%h required ovf=%b cnt=%h fall=%h rise=%h lvl=%h",
                         $time, got_w[32], got_w[31:24], got_w[23:16], got_w[15:8], got_w[7:0],
                         exp_w[32], exp_w[31:24], exp_w[23:16], exp_w[15:8], exp_w[7:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, req);
        end
    endtask

    // Driver: apply inputs for the next edge and predict that edge's outputs.
    // A level is accepted once the last DB synchronised samples all disagree with it.
    task automatic step(input logic r, input logic [7:0] p, input logic [2:0] s, input logic c);
        logic [7:0] s2_pre;
        logic [7:0] nr;
        logic [7:0] nf;
        bit         all_diff;
        @(posedge clk);
        #2;
        rst       = r;
        pin_in    = p;
        sel       = s;
        clr_count = c;
        if (r) begin
            sync_line.delete();
            sync_line.push_back(8'h00);
            sync_line.push_back(8'h00);
            s2_hist.delete();
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_count = '0;
            m_ovf   = 1'b0;
        end else begin
            if (c) begin
                m_count = '0;
                m_ovf   = 1'b0;
            end else if (m_rise[s]) begin
                if (m_count == 8'd255) m_ovf = 1'b1;
                m_count = m_count + 8'd1;
            end
            s2_pre = sync_line.pop_front();
            sync_line.push_back(p);
            s2_hist.push_back(s2_pre);
            if (s2_hist.size() > DB) void'(s2_hist.pop_front());
            nr = '0;
            nf = '0;
            for (int ch = 0; ch < CH; ch++) begin
                if (s2_hist.size() == DB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DB; j++) begin
                        if (s2_hist[j][ch] == m_level[ch]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        if (m_level[ch]) nf[ch] = 1'b1;
                        else             nr[ch] = 1'b1;
                        m_level[ch] = ~m_level[ch];
                    end
                end
            end
            m_rise = nr;
            m_fall = nf;
        end
        exp_q.push_back({CNT_EN ? m_ovf : 1'b0, CNT_EN ? m_count : 8'h00, m_fall, m_rise, m_level});
    endtask

    task automatic pulse_ch3(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b0, 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 8'h00, 3'd3, 1'b0);
    endtask

    initial begin
        logic [7:0] cur;
        int         hold [CH];
        logic       do_rst;
        logic       do_clr;

        // Reset with all pins high, then release and hold them
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'hFF, 3'd0, 1'b0);
        check("reset_pre_level", {24'h0, level_out}, 32'h0000_0000);
        step(1'b0, 8'hFF, 3'd0, 1'b0);
        check("reset_rise_level", {24'h0, level_out}, 32'h0000_00FF);
        check("reset_rise_pulse", {24'h0, rise_pulse}, 32'h0000_00FF);
        step(1'b0, 8'hFF, 3'd0, 1'b0);
        check("reset_rise_once", {24'h0, rise_pulse}, 32'h0000_0000);

        // Return to all-low, then a 3-cycle glitch on channel 0
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, 8'h01, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 3'd0, 1'b0);
        check("glitch_level", {24'h0, level_out}, 32'h0000_0000);

        // Clean edges on channel 2: rise at k+5, fall at the matching edge
        for (int i = 0; i < 6; i++) step(1'b0, 8'h04, 3'd2, 1'b0);
        check("clean_pre_rise", {16'h0, rise_pulse, level_out}, 32'h0000_0000);
        step(1'b0, 8'h04, 3'd2, 1'b0);
        check("clean_rise", {16'h0, rise_pulse, level_out}, 32'h0000_0404);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h04, 3'd2, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 3'd2, 1'b0);
        check("clean_pre_fall", {16'h0, fall_pulse, level_out}, 32'h0000_0004);
        step(1'b0, 8'h00, 3'd2, 1'b0);
        check("clean_fall", {16'h0, fall_pulse, level_out}, 32'h0000_0400);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 3'd2, 1'b0);

        // Randomised phase: per-channel random hold times, sel changes, rare clear/reset
        cur = '0;
        for (int ch = 0; ch < CH; ch++) hold[ch] = $urandom_range(1, 8);
        for (int n = 0; n < 1500; n++) begin
            for (int ch = 0; ch < CH; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    cur[ch]  = ~cur[ch];
                    hold[ch] = $urandom_range(1, 8);
                end
            end
            do_rst = ($urandom_range(0, 199) == 0);
            do_clr = ($urandom_range(0, 31) == 0);
            step(do_rst, cur, 3'($urandom_range(0, 7)), do_clr);
        end

        // Counter wrap on channel 3
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 3'd3, 1'b0);
        step(1'b0, 8'h00, 3'd3, 1'b1);
        for (int n = 0; n < 256; n++) pulse_ch3(5, 5);
        check("wrap_count", {24'h0, event_count}, 32'h0000_0000);
        check("wrap_ovf", {31'h0, count_ovf}, {31'h0, CNT_EN});
        pulse_ch3(5, 5);
        check("wrap_next_count", {24'h0, event_count}, CNT_EN ? 32'h0000_0001 : 32'h0000_0000);
        check("wrap_ovf_sticky", {31'h0, count_ovf}, {31'h0, CNT_EN});

        // Clear coinciding with a rise pulse on the selected channel, count at 7
        for (int n = 0; n < 6; n++) pulse_ch3(5, 5);
        check("pre_clear_count", {24'h0, event_count}, CNT_EN ? 32'h0000_0007 : 32'h0000_0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h08, 3'd3, 1'b0);
            if (m_rise[3]) break;
        end
        step(1'b0, 8'h08, 3'd3, 1'b1);
        step(1'b0, 8'h08, 3'd3, 1'b0);
        check("clear_count", {24'h0, event_count}, 32'h0000_0000);
        check("clear_ovf", {31'h0, count_ovf}, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 3'd3, 1'b0);

        // Let the monitor drain the last expectation
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
